// File: rtl/sram_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_rd_arbiter
// Purpose  : Two-master (IFU, LSU) to one-slave AXI-lite read-channel
//            arbiter for the shared instruction/data SRAM read port. Only one
//            read is outstanding at a time; write channels do not pass here.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            ifu_ar*/ifu_r*   - IFU read master (AR in, R out)
//            lsu_ar*/lsu_r*   - LSU read master (AR in, R out)
//            s_ar*/s_r*       - SRAM read slave (AR out, R in)
// Options  : SRAM_ARB_RR_EN   - when defined, round-robin tie-break with a
//                               last_grant register; otherwise LSU > IFU.
// Revision : 1.0 - initial release
// ============================================================================
module sram_rd_arbiter #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] ifu_araddr,
   input  logic              ifu_arvalid,
   output logic              ifu_arready,
   output logic [DATA_W-1:0] ifu_rdata,
   output logic [1:0]        ifu_rresp,
   output logic              ifu_rvalid,
   input  logic              ifu_rready,
   input  logic [ADDR_W-1:0] lsu_araddr,
   input  logic              lsu_arvalid,
   output logic              lsu_arready,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic [1:0]        lsu_rresp,
   output logic              lsu_rvalid,
   input  logic              lsu_rready,
   output logic [ADDR_W-1:0] s_araddr,
   output logic              s_arvalid,
   input  logic              s_arready,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic [1:0]        s_rresp,
   input  logic              s_rvalid,
   output logic              s_rready
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ADDR  = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;

   localparam logic       OWN_IFU = 1'b0;
   localparam logic       OWN_LSU = 1'b1;

   logic [1:0] r_state;
   logic [1:0] w_next_state;
   logic       r_owner;
   logic       w_next_owner;
   logic       w_winner;
   logic       w_any_req;
   logic       w_own_arvalid;
   logic       w_own_rready;

   assign w_any_req     = ifu_arvalid | lsu_arvalid;
   assign w_own_arvalid = (r_owner == OWN_LSU) ? lsu_arvalid : ifu_arvalid;
   assign w_own_rready  = (r_owner == OWN_LSU) ? lsu_rready  : ifu_rready;

`ifdef SRAM_ARB_RR_EN
   // Reset value LSU makes the IFU win the first tie.
   logic r_last_grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= OWN_LSU;
      end else if ((r_state == S_IDLE) && w_any_req) begin
         r_last_grant <= w_winner;
      end
   end

   always_comb begin
      if (ifu_arvalid && lsu_arvalid) begin
         w_winner = ~r_last_grant;
      end else begin
         w_winner = lsu_arvalid ? OWN_LSU : OWN_IFU;
      end
   end
`else
   assign w_winner = lsu_arvalid ? OWN_LSU : OWN_IFU;
`endif

   // State and owner registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_owner <= OWN_IFU;
      end else begin
         r_state <= w_next_state;
         r_owner <= w_next_owner;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      w_next_owner = r_owner;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_next_state = S_ADDR;
               w_next_owner = w_winner;
            end
         end
         S_ADDR: begin
            // An owner withdrawing its request abandons the grant.
            if (!w_own_arvalid) begin
               w_next_state = S_IDLE;
            end else if (s_arready) begin
               w_next_state = S_DATA;
            end
         end
         S_DATA: begin
            if (s_rvalid && w_own_rready) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      ifu_arready = 1'b0;
      ifu_rvalid  = 1'b0;
      ifu_rdata   = NOP_WORD;
      ifu_rresp   = 2'b00;
      lsu_arready = 1'b0;
      lsu_rvalid  = 1'b0;
      lsu_rdata   = '0;
      lsu_rresp   = 2'b00;
      s_araddr    = '0;
      s_arvalid   = 1'b0;
      s_rready    = 1'b0;
      case (r_state)
         S_ADDR: begin
            s_araddr  = (r_owner == OWN_LSU) ? lsu_araddr : ifu_araddr;
            s_arvalid = w_own_arvalid;
            if (r_owner == OWN_LSU) begin
               lsu_arready = s_arready;
            end else begin
               ifu_arready = s_arready;
            end
         end
         S_DATA: begin
            s_rready = w_own_rready;
            if (r_owner == OWN_LSU) begin
               lsu_rvalid = s_rvalid;
               if (s_rvalid) begin
                  lsu_rdata = s_rdata;
                  lsu_rresp = s_rresp;
               end
            end else begin
               ifu_rvalid = s_rvalid;
               if (s_rvalid) begin
                  ifu_rdata = s_rdata;
                  ifu_rresp = s_rresp;
               end
            end
         end
         default: begin
            // Idle drains any stray slave beat without forwarding it.
            s_rready = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_rd_arbiter
// Purpose  : Self-checking bench for sram_rd_arbiter. A transaction-level
//            model predicts every output each cycle; directed scenarios add
//            hand-computed expectations on grant order, latency and data.
// Options  : SRAM_ARB_RR_EN selects round-robin expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_rd_arbiter;

   localparam logic [31:0] NOP = 32'h00000013;
   localparam logic [31:0] IDLE_BUS = 32'hBAD0BAD0;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ifu_araddr, lsu_araddr, s_araddr;
   logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
   logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
   logic [31:0] ifu_rdata, lsu_rdata, s_rdata;
   logic [1:0]  ifu_rresp, lsu_rresp, s_rresp;
   logic        s_arvalid, s_arready, s_rvalid, s_rready;

   always #5 clk = ~clk;

   sram_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .NOP_WORD(NOP)) dut (
      .clk(clk), .rst(rst),
      .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
      .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
      .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
      .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // SRAM contents seen by the slave model
   function automatic logic [31:0] mem_data(input logic [31:0] a);
      case (a)
         32'h80000000: mem_data = 32'hDEADBEEF;
         32'h80000004: mem_data = 32'h00100093;
         32'h80001000: mem_data = 32'hCAFEF00D;
         32'h80002000: mem_data = 32'h12345678;
         default:      mem_data = ~a;
      endcase
   endfunction

   function automatic logic [1:0] mem_resp(input logic [31:0] a);
      mem_resp = (a == 32'h80001000) ? 2'b10 : 2'b00;
   endfunction

   // ---------------- slave: responds slv_delay cycles after AR ----------------
   int slv_delay = 0;
   int slv_beats = 0;

   initial begin
      logic        ar_hs, r_hs, pend;
      logic [31:0] hs_addr, paddr;
      int          cnt;
      s_rvalid = 1'b0; s_rdata = IDLE_BUS; s_rresp = 2'b00;
      pend = 1'b0; cnt = 0; paddr = '0;
      forever begin
         @(negedge clk);
         ar_hs   = s_arvalid & s_arready;
         r_hs    = s_rvalid & s_rready;
         hs_addr = s_araddr;
         @(posedge clk);
         #1;
         if (r_hs) begin
            slv_beats++;
            s_rvalid = 1'b0; s_rdata = IDLE_BUS; s_rresp = 2'b00;
         end
         if (ar_hs) begin
            if (slv_delay == 0) begin
               s_rvalid = 1'b1; s_rdata = mem_data(hs_addr); s_rresp = mem_resp(hs_addr);
            end else begin
               pend = 1'b1; cnt = slv_delay - 1; paddr = hs_addr;
            end
         end else if (pend) begin
            if (cnt == 0) begin
               s_rvalid = 1'b1; s_rdata = mem_data(paddr); s_rresp = mem_resp(paddr);
               pend = 1'b0;
            end else begin
               cnt--;
            end
         end
      end
   end

   // ---------------- observer: logs handshakes, drops accepted requests ----------------
   logic [31:0] ar_log[$];
   int          ifu_beats = 0, lsu_beats = 0;
   logic [31:0] ifu_last = '0, lsu_last = '0;
   logic [1:0]  lsu_last_resp = '0;

   initial begin
      logic ih, lh;
      forever begin
         @(negedge clk);
         if (s_arvalid && s_arready) ar_log.push_back(s_araddr);
         ih = ifu_arvalid & ifu_arready;
         lh = lsu_arvalid & lsu_arready;
         if (ifu_rvalid && ifu_rready) begin ifu_beats++; ifu_last = ifu_rdata; end
         if (lsu_rvalid && lsu_rready) begin lsu_beats++; lsu_last = lsu_rdata; lsu_last_resp = lsu_rresp; end
         @(posedge clk);
         #1;
         if (ih) ifu_arvalid = 1'b0;
         if (lh) lsu_arvalid = 1'b0;
      end
   end

   // ---------------- transaction-level reference model ----------------
   // m_own: 0 = no grant, 1 = IFU, 2 = LSU. m_addr_done: address accepted.
   initial begin
      int          m_own, m_last, n_own, n_last, win;
      bit          m_addr_done, n_addr_done, m_valid, rst_s;
      logic        own_arv, own_rr;
      logic [31:0] own_addr;
      logic [35:0] e_ifu, e_lsu, beat;
      logic [33:0] e_s;
      m_own = 0; m_last = 2; m_addr_done = 0; m_valid = 0;
      forever begin
         @(negedge clk);
         e_ifu = {1'b0, 1'b0, 2'b00, NOP};
         e_lsu = '0;
         e_s   = {1'b0, 1'b1, 32'h0};
         own_arv  = (m_own == 2) ? lsu_arvalid : ifu_arvalid;
         own_rr   = (m_own == 2) ? lsu_rready  : ifu_rready;
         own_addr = (m_own == 2) ? lsu_araddr  : ifu_araddr;
         if (m_own != 0) begin
            if (!m_addr_done) begin
               e_s = {own_arv, 1'b0, own_addr};
               if (m_own == 1) e_ifu[35] = s_arready; else e_lsu[35] = s_arready;
            end else begin
               e_s = {1'b0, own_rr, 32'h0};
               if (m_own == 1) begin
                  beat  = s_rvalid ? {2'b00, s_rresp, s_rdata} : {4'b0000, NOP};
                  e_ifu = {1'b0, s_rvalid, beat[33:0]};
               end else begin
                  beat  = s_rvalid ? {2'b00, s_rresp, s_rdata} : 36'h0;
                  e_lsu = {1'b0, s_rvalid, beat[33:0]};
               end
            end
         end
         if (m_valid) begin
            chk("ifu_side", {ifu_arready, ifu_rvalid, ifu_rresp, ifu_rdata}, e_ifu);
            chk("lsu_side", {lsu_arready, lsu_rvalid, lsu_rresp, lsu_rdata}, e_lsu);
            chk("slave_side", {s_arvalid, s_rready, s_araddr}, e_s);
         end
         rst_s = rst;
         n_own = m_own; n_addr_done = m_addr_done; n_last = m_last;
         if (rst) begin
            n_own = 0; n_addr_done = 0; n_last = 2;
         end else if (m_own == 0) begin
            if (ifu_arvalid || lsu_arvalid) begin
`ifdef SRAM_ARB_RR_EN
               if (ifu_arvalid && lsu_arvalid) win = (m_last == 1) ? 2 : 1;
               else win = lsu_arvalid ? 2 : 1;
`else
               win = lsu_arvalid ? 2 : 1;
`endif
               n_own = win; n_last = win; n_addr_done = 0;
            end
         end else if (!m_addr_done) begin
            if (!own_arv) n_own = 0;
            else if (s_arready) n_addr_done = 1;
         end else if (s_rvalid && own_rr) begin
            n_own = 0; n_addr_done = 0;
         end
         @(posedge clk);
         m_own = n_own; m_addr_done = n_addr_done; m_last = n_last;
         if (rst_s) m_valid = 1;
      end
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int b_ifu, b_lsu, b_slv, b_ar;
      logic [31:0] first_addr, second_addr;
      rst = 1'b1;
      ifu_araddr = '0; ifu_arvalid = 1'b0; ifu_rready = 1'b0;
      lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_rready = 1'b0;
      s_arready = 1'b0;

      // Reset held for two cycles, then idle
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("rst_s_arvalid", s_arvalid, 1'b0);
      chk("rst_arready", {ifu_arready, lsu_arready}, 2'b00);
      chk("rst_rvalid", {ifu_rvalid, lsu_rvalid}, 2'b00);
      chk("rst_s_rready", s_rready, 1'b1);
      chk("rst_ifu_rdata", ifu_rdata, 32'h00000013);
      chk("rst_lsu_rdata", lsu_rdata, 32'h0);

      // Simultaneous request: LSU first (round-robin: IFU first)
`ifdef SRAM_ARB_RR_EN
      first_addr = 32'h80000004; second_addr = 32'h80001000;
`else
      first_addr = 32'h80001000; second_addr = 32'h80000004;
`endif
      cyc(1);
      ifu_rready = 1'b1; lsu_rready = 1'b1; s_arready = 1'b1; slv_delay = 0;
      ifu_araddr = 32'h80000004; lsu_araddr = 32'h80001000;
      ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
      @(negedge clk);
      chk("tie_lat0_s_arvalid", s_arvalid, 1'b0);
      cyc(1);
      @(negedge clk);
      chk("tie_first_s_araddr", s_araddr, first_addr);
      cyc(1);
      for (int i = 0; i < 40 && (ifu_beats < 1 || lsu_beats < 1); i++) cyc(1);
      chk("tie_done", {ifu_beats[7:0], lsu_beats[7:0]}, 16'h0101);
      chk("tie_ar_count", ar_log.size(), 2);
      chk("tie_order0", ar_log[0], first_addr);
      chk("tie_order1", ar_log[1], second_addr);
      chk("tie_lsu_data", lsu_last, 32'hCAFEF00D);
      chk("tie_lsu_resp", lsu_last_resp, 2'b10);
      chk("tie_ifu_data", ifu_last, 32'h00100093);

      // IFU alone, 1-cycle grant latency, data next cycle
      cyc(2);
      b_lsu = lsu_beats;
      ifu_araddr = 32'h80000000; ifu_arvalid = 1'b1;
      @(negedge clk);
      chk("solo_lat0_s_arvalid", s_arvalid, 1'b0);
      cyc(1);
      @(negedge clk);
      chk("solo_s_arvalid", s_arvalid, 1'b1);
      chk("solo_s_araddr", s_araddr, 32'h80000000);
      chk("solo_ifu_arready", ifu_arready, 1'b1);
      cyc(1);
      @(negedge clk);
      chk("solo_ifu_rvalid", ifu_rvalid, 1'b1);
      chk("solo_ifu_rdata", ifu_rdata, 32'hDEADBEEF);
      chk("solo_lsu_rvalid", lsu_rvalid, 1'b0);
      cyc(2);
      chk("solo_lsu_beats", lsu_beats, b_lsu);

      // LSU back-pressure while IFU waits
      cyc(1);
      b_ifu = ifu_beats; b_lsu = lsu_beats;
      lsu_rready = 1'b0;
      lsu_araddr = 32'h80001000; lsu_arvalid = 1'b1;
      cyc(1);
      ifu_araddr = 32'h80000004; ifu_arvalid = 1'b1;
      cyc(1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_s_rready", s_rready, 1'b0);
         chk("bp_ifu_arready", ifu_arready, 1'b0);
         chk("bp_lsu_rvalid", lsu_rvalid, 1'b1);
         cyc(1);
      end
      lsu_rready = 1'b1;
      cyc(1);
      @(negedge clk);
      chk("bp_turnaround_s_arvalid", s_arvalid, 1'b0);
      cyc(1);
      @(negedge clk);
      chk("bp_ifu_grant_s_arvalid", s_arvalid, 1'b1);
      chk("bp_ifu_grant_s_araddr", s_araddr, 32'h80000004);
      cyc(1);
      for (int i = 0; i < 20 && ifu_beats < b_ifu + 1; i++) cyc(1);
      chk("bp_lsu_beats", lsu_beats, b_lsu + 1);
      chk("bp_ifu_beats", ifu_beats, b_ifu + 1);

      // Reset while the slave response is still pending
      cyc(2);
      b_ifu = ifu_beats; b_lsu = lsu_beats; b_slv = slv_beats;
      slv_delay = 3;
      ifu_araddr = 32'h80002000; ifu_arvalid = 1'b1;
      cyc(2);
      @(negedge clk);
      chk("rst_mid_in_data", {ifu_rvalid, s_rready}, 2'b01);
      cyc(1);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      for (int i = 0; i < 20 && slv_beats < b_slv + 1; i++) cyc(1);
      chk("rst_mid_drained", slv_beats, b_slv + 1);
      chk("rst_mid_no_ifu_beat", ifu_beats, b_ifu);
      chk("rst_mid_no_lsu_beat", lsu_beats, b_lsu);
      @(negedge clk);
      chk("rst_mid_idle_s_rready", s_rready, 1'b1);
      slv_delay = 0;

      // Owner withdraws in ADDR; pending LSU then granted
      cyc(2);
      b_lsu = lsu_beats; b_ar = ar_log.size();
      s_arready = 1'b0;
      ifu_araddr = 32'h80000008; ifu_arvalid = 1'b1;
      cyc(1);
      lsu_araddr = 32'h80001000; lsu_arvalid = 1'b1;
      @(negedge clk);
      chk("wd_ifu_s_araddr", {s_arvalid, s_araddr}, {1'b1, 32'h80000008});
      cyc(1);
      ifu_arvalid = 1'b0;
      @(negedge clk);
      chk("wd_dropped_s_arvalid", s_arvalid, 1'b0);
      cyc(1);
      s_arready = 1'b1;
      @(negedge clk);
      chk("wd_idle_s_arvalid", s_arvalid, 1'b0);
      cyc(1);
      @(negedge clk);
      chk("wd_lsu_grant", {s_arvalid, s_araddr}, {1'b1, 32'h80001000});
      cyc(1);
      for (int i = 0; i < 20 && lsu_beats < b_lsu + 1; i++) cyc(1);
      chk("wd_lsu_beat", lsu_beats, b_lsu + 1);
      chk("wd_ar_count", ar_log.size(), b_ar + 1);
      chk("wd_ar_last", ar_log[ar_log.size() - 1], 32'h80001000);

      cyc(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
